dma_rx_axis_arbiter: RTL and testbench

- Parametrised N-channel AXI4-Stream packet arbiter feeding the DMA engine MAC-rx stream port (64-bit data, 128-bit TUSER).
- Replaces the single-port MAC rx hookup.
- Round-robin arbitration at packet boundaries.
- Tags each packet with its one-hot DMA source port in TUSER.
- Registered two-entry skid output, so M_AXIS has no combinational path from inputs.

---
 rtl/dma_rx_axis_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_dma_rx_axis_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rx_axis_arbiter.sv
// dma_rx_axis_arbiter
//   N-channel AXI4-Stream packet arbiter that feeds the DMA engine MAC-rx port.
//   Arbitration is round-robin and happens only at packet boundaries. Each
//   IDLE cycle that sees a valid channel is a one-cycle arbitration bubble.
//   The merged stream leaves through a registered two-entry skid buffer, so
//   nothing on M_AXIS depends combinationally on the S_AXIS inputs.
//
// Ports
//   axi_clk, rst_n         clock, asynchronous active-low reset
//   S_AXIS_T*              C_NUM_CH packed slave channels (channel i at [i*W +: W])
//   S_AXIS_TREADY          ready, asserted only toward the locked channel
//   M_AXIS_T*              merged master stream (TUSER optionally src-tagged)
//   grant                  one-hot locked channel, 0 while idle
//
// Optional feature (macro DMA_RX_ARB_STATS_EN)
//   pkt_cnt      out  C_NUM_CH*32  per-channel accepted-packet counters
//   pkt_cnt_clr  in   1            synchronous clear of all counters
module dma_rx_axis_arbiter #(
    parameter int C_NUM_CH       = 4,
    parameter int C_DATA_WIDTH   = 64,
    parameter int C_TUSER_WIDTH  = 128,
    parameter int C_SRC_PORT_POS = 16,
    parameter int C_TAG_SRC      = 1
) (
    input  logic                                  axi_clk,
    input  logic                                  rst_n,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_NUM_CH*C_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_NUM_CH*C_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic [C_NUM_CH-1:0]                   S_AXIS_TVALID,
    input  logic [C_NUM_CH-1:0]                   S_AXIS_TLAST,
    output logic [C_NUM_CH-1:0]                   S_AXIS_TREADY,
    output logic [C_DATA_WIDTH-1:0]               M_AXIS_TDATA,
    output logic [C_DATA_WIDTH/8-1:0]             M_AXIS_TSTRB,
    output logic [C_TUSER_WIDTH-1:0]              M_AXIS_TUSER,
    output logic                                  M_AXIS_TVALID,
    output logic                                  M_AXIS_TLAST,
    input  logic                                  M_AXIS_TREADY,
    output logic [C_NUM_CH-1:0]                   grant
`ifdef DMA_RX_ARB_STATS_EN
    ,
    output logic [C_NUM_CH*32-1:0]                pkt_cnt,
    input  logic                                  pkt_cnt_clr
`endif
);

    localparam int SW = C_DATA_WIDTH / 8;
    localparam int IW = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;
    // Buffer entries hold {last, user, strb, data}
    localparam int BW = 1 + C_TUSER_WIDTH + SW + C_DATA_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [C_NUM_CH-1:0] grant_q, grant_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [IW-1:0]       last_q, last_d;

    logic [BW-1:0]       head_q, tail_q;
    logic [1:0]          cnt_q;

    logic                full, push, pop;
    logic                sel_valid, sel_last;
    logic [C_DATA_WIDTH-1:0]  sel_data;
    logic [SW-1:0]            sel_strb;
    logic [C_TUSER_WIDTH-1:0] sel_user;
    logic [BW-1:0]       sel_beat;

    logic                pick_found;
    logic [IW-1:0]       pick_idx, cand;

    // Mux the locked channel onto the buffer write port and apply the tag.
    always_comb begin
        sel_data  = S_AXIS_TDATA[gidx_q*C_DATA_WIDTH +: C_DATA_WIDTH];
        sel_strb  = S_AXIS_TSTRB[gidx_q*SW +: SW];
        sel_user  = S_AXIS_TUSER[gidx_q*C_TUSER_WIDTH +: C_TUSER_WIDTH];
        sel_valid = S_AXIS_TVALID[gidx_q];
        sel_last  = S_AXIS_TLAST[gidx_q];
        // DMA source ports are the odd one-hot codes 0x02/0x08/0x20/0x80
        if (C_TAG_SRC != 0)
            sel_user[C_SRC_PORT_POS +: 8] = 8'd1 << (2*gidx_q + 1);
    end

    assign sel_beat = {sel_last, sel_user, sel_strb, sel_data};

    // full is registered state, so TREADY never depends on M_AXIS_TREADY.
    assign full          = (cnt_q == 2'd2);
    assign push          = (state_q == ST_PKT) && !full && sel_valid;
    assign pop           = (cnt_q != 2'd0) && M_AXIS_TREADY;
    assign S_AXIS_TREADY = ((state_q == ST_PKT) && !full) ? grant_q : '0;
    assign grant         = grant_q;

    // Round-robin scan starting just after the last granted channel.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= C_NUM_CH; k++) begin
            cand = IW'((int'(last_q) + k) % C_NUM_CH);
            if (!pick_found && S_AXIS_TVALID[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_PKT;
                    gidx_d  = pick_idx;
                    grant_d = C_NUM_CH'(1) << pick_idx;
                end
            end
            default: begin
                if (push && sel_last) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(C_NUM_CH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

    // Two-entry skid buffer: head drives M_AXIS, tail only fills when the
    // head is stalled. A push while full cannot happen (TREADY is low).
    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        head_q <= sel_beat;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= sel_beat;
                    end else if (push) begin
                        tail_q <= sel_beat;
                        cnt_q  <= 2'd2;
                    end else if (pop) begin
                        cnt_q  <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        cnt_q  <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign M_AXIS_TVALID = (cnt_q != 2'd0);
    assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = head_q;

`ifdef DMA_RX_ARB_STATS_EN
    // Clear wins over a simultaneous TLAST beat.
    logic [C_NUM_CH*32-1:0] pkt_cnt_q;
    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n)
            pkt_cnt_q <= '0;
        else if (pkt_cnt_clr)
            pkt_cnt_q <= '0;
        else if (push && sel_last)
            pkt_cnt_q[gidx_q*32 +: 32] <= pkt_cnt_q[gidx_q*32 +: 32] + 32'd1;
    end
    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_dma_rx_axis_arbiter.sv
// Testbench for dma_rx_axis_arbiter: scenario tasks against a queue-based
// reference model (per-channel packet queues, expected output queue, buffer
// occupancy and round-robin pointer).
module tb_dma_rx_axis_arbiter;
    localparam int NCH = 4, W = 64, SW = 8, UW = 128, POS = 16;

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic axi_clk = 1'b0;
    logic rst_n;
    logic [NCH*W-1:0]  S_AXIS_TDATA;
    logic [NCH*SW-1:0] S_AXIS_TSTRB;
    logic [NCH*UW-1:0] S_AXIS_TUSER;
    logic [NCH-1:0]    S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
    logic [W-1:0]      M_AXIS_TDATA;
    logic [SW-1:0]     M_AXIS_TSTRB;
    logic [UW-1:0]     M_AXIS_TUSER;
    logic              M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
    logic [NCH-1:0]    grant;
`ifdef DMA_RX_ARB_STATS_EN
    logic [NCH*32-1:0] pkt_cnt;
    logic              pkt_cnt_clr;
`endif

    dma_rx_axis_arbiter #(.C_NUM_CH(NCH), .C_DATA_WIDTH(W), .C_TUSER_WIDTH(UW),
                          .C_SRC_PORT_POS(POS), .C_TAG_SRC(1)) dut (
        .axi_clk(axi_clk), .rst_n(rst_n),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
        .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
        .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .grant(grant)
`ifdef DMA_RX_ARB_STATS_EN
        , .pkt_cnt(pkt_cnt), .pkt_cnt_clr(pkt_cnt_clr)
`endif
    );

    always #5 axi_clk = ~axi_clk;

    int vectors = 0, miscompares = 0;

    // Reference model state
    beat_t src_q[NCH][$];
    beat_t exp_q[$];
    int    hold[NCH];
    int    m_acc[NCH], m_pkts[NCH];
    bit    m_gv;          // a channel is locked
    int    m_g, m_last, occ;
    bit    rnd_gaps;
    logic  mready;
    // Expectations for the current cycle, produced by step()
    logic [NCH-1:0] vld, exp_tready, exp_grant;
    bit    exp_mv;
    beat_t exp_head;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            src_q[c].delete(); hold[c] = 0; m_acc[c] = 0; m_pkts[c] = 0;
        end
        exp_q.delete();
        m_gv = 0; m_g = 0; m_last = NCH - 1; occ = 0; rnd_gaps = 0;
    endtask

    task automatic gen_pkt(input int c, input int len, input bit zero_tag);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = {$urandom, $urandom};
            b.s = 8'($urandom);
            b.u = {$urandom, $urandom, $urandom, $urandom};
            if (zero_tag) b.u[POS +: 8] = 8'h00;
            b.l = (i == len - 1);
            src_q[c].push_back(b);
        end
    endtask

    function automatic bit busy();
        bit r;
        r = m_gv || (exp_q.size() != 0) || (occ != 0);
        for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) r = 1;
        return r;
    endfunction

    // One clock: drive inputs at the falling edge, derive this cycle's
    // expectations, then advance the model across the coming rising edge.
    task automatic step();
        beat_t b;
        bit push, pop;
        @(negedge axi_clk);
        for (int c = 0; c < NCH; c++) begin
            if (hold[c] > 0) hold[c]--;
            vld[c] = (src_q[c].size() > 0) && (hold[c] == 0);
            b = vld[c] ? src_q[c][0] : '{default: '0};
            S_AXIS_TDATA[c*W +: W]   = b.d;
            S_AXIS_TSTRB[c*SW +: SW] = b.s;
            S_AXIS_TUSER[c*UW +: UW] = b.u;
            S_AXIS_TLAST[c]          = b.l;
        end
        S_AXIS_TVALID = vld;
        M_AXIS_TREADY = mready;
        #1;
        exp_grant  = m_gv ? (4'b0001 << m_g) : 4'b0000;
        exp_tready = (m_gv && occ < 2) ? exp_grant : 4'b0000;
        exp_mv     = (occ > 0);
        exp_head   = exp_mv ? exp_q[0] : '{default: '0};
        push = m_gv && (occ < 2) && vld[m_g];
        pop  = exp_mv && mready;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            b = src_q[m_g].pop_front();
            b.u[POS +: 8] = 8'd1 << (2*m_g + 1);
            exp_q.push_back(b);
            m_acc[m_g]++;
            if (rnd_gaps && $urandom_range(0, 3) == 0) hold[m_g] = $urandom_range(1, 3);
            if (b.l) begin m_gv = 0; m_last = m_g; m_pkts[m_g]++; end
        end else if (!m_gv) begin
            for (int k = 1; k <= NCH; k++) begin
                if (vld[(m_last + k) % NCH]) begin
                    m_gv = 1; m_g = (m_last + k) % NCH; break;
                end
            end
        end
        occ = occ + int'(push) - int'(pop);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mready = 1'b0; model_reset();
        repeat (3) @(negedge axi_clk);
        vectors++;
        if ({S_AXIS_TREADY, grant, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got tready=%b grant=%b mvalid=%b data=%h want all zero", S_AXIS_TREADY, grant, M_AXIS_TVALID, M_AXIS_TDATA);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            vectors++;
            if ({S_AXIS_TREADY, grant, M_AXIS_TVALID} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle: cycle %0d got tready=%b grant=%b mvalid=%b want 0/0/0", t, S_AXIS_TREADY, grant, M_AXIS_TVALID);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] order[$];
        logic [NCH-1:0] prev = '0;
        logic [NCH-1:0] want[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int t = 0;
        mready = 1'b1;
        for (int p = 0; p < 2; p++) for (int c = 0; c < NCH; c++) gen_pkt(c, 2, 0);
        while (busy() && t < 500) begin
            step(); t++;
            vectors++;
            if ({S_AXIS_TREADY, grant, M_AXIS_TVALID} !== {exp_tready, exp_grant, exp_mv}) begin
                miscompares++;
                $display("FAIL rr_ctrl: got tready=%b grant=%b mvalid=%b want %b/%b/%b", S_AXIS_TREADY, grant, M_AXIS_TVALID, exp_tready, exp_grant, exp_mv);
            end
            if (exp_mv) begin
                vectors++;
                if ({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST} !== {exp_head.d, exp_head.s, exp_head.u, exp_head.l}) begin
                    miscompares++;
                    $display("FAIL rr_beat: got %h want %h", {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST}, {exp_head.d, exp_head.s, exp_head.u, exp_head.l});
                end
            end
            if (grant != 0 && prev == 0) order.push_back(grant);
            prev = grant;
        end
        vectors++;
        if (busy() || order.size() < 5) begin
            miscompares++;
            $display("FAIL rr_timeout: got %0d grants in %0d cycles want >=5 and drained", order.size(), t);
        end
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            vectors++;
            if (order[i] !== want[i]) begin
                miscompares++;
                $display("FAIL rr_order: packet %0d got grant %b want %b", i, order[i], want[i]);
            end
        end
    endtask

    task automatic test_latency();
        int t = 0, first = -1;
        mready = 1'b1;
        gen_pkt(2, 3, 1);
        while (busy() && t < 50) begin
            step();
            vectors++;
            if ({S_AXIS_TREADY, grant, M_AXIS_TVALID} !== {exp_tready, exp_grant, exp_mv}) begin
                miscompares++;
                $display("FAIL lat_ctrl: got tready=%b grant=%b mvalid=%b want %b/%b/%b", S_AXIS_TREADY, grant, M_AXIS_TVALID, exp_tready, exp_grant, exp_mv);
            end
            if (exp_mv) begin
                vectors++;
                if ({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST} !== {exp_head.d, exp_head.s, exp_head.u, exp_head.l}) begin
                    miscompares++;
                    $display("FAIL lat_beat: got %h want %h", {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST}, {exp_head.d, exp_head.s, exp_head.u, exp_head.l});
                end
            end
            if (M_AXIS_TVALID) begin
                vectors++;
                if (M_AXIS_TUSER[23:16] !== 8'h20) begin
                    miscompares++;
                    $display("FAIL lat_tag: got %h want 20", M_AXIS_TUSER[23:16]);
                end
                if (first < 0) first = t;
            end
            t++;
        end
        vectors++;
        if (first != 2) begin
            miscompares++;
            $display("FAIL lat_first_beat: got cycle %0d want 2", first);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int t = 0, nout = 0, nfull = 0;
        gen_pkt(1, 8, 0);
        while (busy() && t < 200) begin
            mready = pat[t % 4];
            step(); t++;
            vectors++;
            if ({S_AXIS_TREADY, grant, M_AXIS_TVALID} !== {exp_tready, exp_grant, exp_mv}) begin
                miscompares++;
                $display("FAIL bp_ctrl: got tready=%b grant=%b mvalid=%b want %b/%b/%b", S_AXIS_TREADY, grant, M_AXIS_TVALID, exp_tready, exp_grant, exp_mv);
            end
            if (exp_mv) begin
                vectors++;
                if ({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST} !== {exp_head.d, exp_head.s, exp_head.u, exp_head.l}) begin
                    miscompares++;
                    $display("FAIL bp_beat: got %h want %h", {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST}, {exp_head.d, exp_head.s, exp_head.u, exp_head.l});
                end
            end
            if (grant[1] && exp_mv && exp_tready == 0) nfull++;
            if (M_AXIS_TVALID && mready) nout++;
        end
        vectors++;
        if (nout != 8 || nfull == 0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d beats (%0d full cycles) want 8 beats and a full buffer", nout, nfull);
        end
    endtask

    task automatic test_drop_valid();
        logic [NCH-1:0] order[$];
        logic [NCH-1:0] prev = '0;
        int t = 0, a0 = m_acc[0];
        bit dropped = 0;
        mready = 1'b1;
        gen_pkt(0, 6, 0);
        while ((busy() || t < 3) && t < 200) begin
            step();
            if (t == 2) gen_pkt(3, 2, 0);
            if (!dropped && m_acc[0] == a0 + 2) begin hold[0] = 6; dropped = 1; end
            t++;
            vectors++;
            if ({S_AXIS_TREADY, grant, M_AXIS_TVALID} !== {exp_tready, exp_grant, exp_mv}) begin
                miscompares++;
                $display("FAIL drop_ctrl: got tready=%b grant=%b mvalid=%b want %b/%b/%b", S_AXIS_TREADY, grant, M_AXIS_TVALID, exp_tready, exp_grant, exp_mv);
            end
            if (exp_mv) begin
                vectors++;
                if ({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST} !== {exp_head.d, exp_head.s, exp_head.u, exp_head.l}) begin
                    miscompares++;
                    $display("FAIL drop_beat: got %h want %h", {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST}, {exp_head.d, exp_head.s, exp_head.u, exp_head.l});
                end
            end
            if (grant != 0 && grant != prev) order.push_back(grant);
            prev = grant;
        end
        vectors++;
        if (order.size() != 2 || order[0] !== 4'b0001 || order[1] !== 4'b1000) begin
            miscompares++;
            $display("FAIL drop_grant_seq: got %0d grants first=%b want 0001 then 1000", order.size(), (order.size() > 0) ? order[0] : 4'b0000);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0, nout = 0;
        mready = 1'b1;
        gen_pkt(2, 6, 0);
        repeat (4) step();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({S_AXIS_TREADY, grant, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TUSER} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got tready=%b grant=%b mvalid=%b data=%h want all zero", S_AXIS_TREADY, grant, M_AXIS_TVALID, M_AXIS_TDATA);
        end
        S_AXIS_TVALID = '0;
        model_reset();
`ifdef DMA_RX_ARB_STATS_EN
        vectors++;
        if (pkt_cnt !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_stats: got %h want 0", pkt_cnt);
        end
`endif
        @(negedge axi_clk) rst_n = 1'b1;
        gen_pkt(1, 4, 0);
        while (busy() && t < 100) begin
            step(); t++;
            vectors++;
            if ({S_AXIS_TREADY, grant, M_AXIS_TVALID} !== {exp_tready, exp_grant, exp_mv}) begin
                miscompares++;
                $display("FAIL rst_mid_ctrl: got tready=%b grant=%b mvalid=%b want %b/%b/%b", S_AXIS_TREADY, grant, M_AXIS_TVALID, exp_tready, exp_grant, exp_mv);
            end
            if (exp_mv) begin
                vectors++;
                if ({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST} !== {exp_head.d, exp_head.s, exp_head.u, exp_head.l}) begin
                    miscompares++;
                    $display("FAIL rst_mid_beat: got %h want %h", {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST}, {exp_head.d, exp_head.s, exp_head.u, exp_head.l});
                end
            end
            if (M_AXIS_TVALID && mready) nout++;
        end
        vectors++;
        if (nout != 4) begin
            miscompares++;
            $display("FAIL rst_mid_count: got %0d beats want 4", nout);
        end
    endtask

    task automatic test_random();
        int t = 0;
        rnd_gaps = 1;
        for (int p = 0; p < 20; p++) gen_pkt($urandom_range(0, NCH-1), $urandom_range(1, 5), 0);
        while ((busy() || t < 600) && t < 5000) begin
            mready = ($urandom_range(0, 3) != 0);
            step(); t++;
            if (t < 600 && $urandom_range(0, 15) == 0) gen_pkt($urandom_range(0, NCH-1), $urandom_range(1, 5), 0);
            vectors++;
            if ({S_AXIS_TREADY, grant, M_AXIS_TVALID} !== {exp_tready, exp_grant, exp_mv}) begin
                miscompares++;
                $display("FAIL rand_ctrl: cycle %0d got tready=%b grant=%b mvalid=%b want %b/%b/%b", t, S_AXIS_TREADY, grant, M_AXIS_TVALID, exp_tready, exp_grant, exp_mv);
            end
            if (exp_mv) begin
                vectors++;
                if ({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST} !== {exp_head.d, exp_head.s, exp_head.u, exp_head.l}) begin
                    miscompares++;
                    $display("FAIL rand_beat: cycle %0d got %h want %h", t, {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST}, {exp_head.d, exp_head.s, exp_head.u, exp_head.l});
                end
            end
        end
        rnd_gaps = 0;
        vectors++;
        if (busy()) begin
            miscompares++;
            $display("FAIL rand_timeout: got traffic pending after %0d cycles want drained", t);
        end
    endtask

`ifdef DMA_RX_ARB_STATS_EN
    task automatic test_stats();
        for (int c = 0; c < NCH; c++) begin
            vectors++;
            if (pkt_cnt[c*32 +: 32] !== 32'(m_pkts[c])) begin
                miscompares++;
                $display("FAIL stats_count: ch%0d got %0d want %0d", c, pkt_cnt[c*32 +: 32], m_pkts[c]);
            end
        end
        pkt_cnt_clr = 1'b1;
        @(negedge axi_clk) pkt_cnt_clr = 1'b0;
        vectors++;
        if (pkt_cnt !== '0) begin
            miscompares++;
            $display("FAIL stats_clear: got %h want 0", pkt_cnt);
        end
    endtask
`endif

    initial begin
        S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0;
        S_AXIS_TVALID = '0; S_AXIS_TLAST = '0; M_AXIS_TREADY = 1'b0;
`ifdef DMA_RX_ARB_STATS_EN
        pkt_cnt_clr = 1'b0;
`endif
        test_reset();
        test_round_robin();
        test_latency();
        test_backpressure();
        test_drop_valid();
        test_reset_mid();
        test_random();
`ifdef DMA_RX_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
